// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller and its RAM.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
package ram_fifo_pkg;
  localparam int DATA_W = 6;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 12;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [ADDR_W+1:0] lvl_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
  localparam ptr_t LAST_PTR  = ptr_t'(DEPTH - 1);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer valid-ready streams of the RAM FIFO controller.
// master = environment side, slave = controller side.
interface ram_fifo_ctrl_if;
  import ram_fifo_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ram_fifo_skid.sv
// Output register plus one skid entry; absorbs RAM read data arriving one cycle
// after issue so the consumer sees a clean, stable valid/ready stream.
module ram_fifo_skid
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              skid_valid
);

  logic [DATA_W-1:0] skid_data;
  logic              pop;

  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (pop || !out_valid) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= cap_valid;
        if (cap_valid) skid_data <= cap_data;
      end else begin
        out_valid <= cap_valid;
        if (cap_valid) out_data <= cap_data;
      end
    end else if (cap_valid) begin
      skid_data  <= cap_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with 1-cycle registered reads.
// Owns pointers and occupancy; reads are issued only when the skid pair has room.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ram_fifo_ctrl_if.slave    bus,
  output logic              ram_write_en,
  output ptr_t              ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_read_en,
  output ptr_t              ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data,
  output lvl_t              fill_level,
  output logic              empty,
  output logic              full
);

  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  cnt_t              mem_count;
  logic              rd_pending;
  logic              push;
  logic              pop;
  logic              out_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        slots_after_pop;

  // Full is judged on the registered count only, so a same-cycle read never frees a write.
  assign bus.in_ready = !rst && (mem_count < DEPTH_CNT);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = out_valid & bus.out_ready;

  assign slots_after_pop = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pending} - {1'b0, pop};

  assign ram_write_en   = push;
  assign ram_write_addr = wr_ptr;
  assign ram_write_data = bus.in_data;
  assign ram_read_en    = (mem_count != '0) && (slots_after_pop < 2'd2);
  assign ram_read_addr  = rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (push)        wr_ptr <= ptr_inc(wr_ptr);
      if (ram_read_en) rd_ptr <= ptr_inc(rd_ptr);
      rd_pending <= ram_read_en;
      case ({push, ram_read_en})
        2'b10:   mem_count <= mem_count + cnt_t'(1);
        2'b01:   mem_count <= mem_count - cnt_t'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

  ram_fifo_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .cap_valid  (rd_pending),
    .cap_data   (ram_read_data),
    .out_ready  (bus.out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .skid_valid (skid_valid)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

  assign fill_level = lvl_t'(mem_count) + lvl_t'(rd_pending) + lvl_t'(out_valid) + lvl_t'(skid_valid);
  assign empty      = (fill_level == '0);
  assign full       = (mem_count == DEPTH_CNT);

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly in front of the 6-bit x 8-bit-address dual-port RAM.
- It drives the RAM write port from a valid/ready input stream and the RAM read port into a valid/ready output stream.
- It owns the circular read/write pointers, the occupancy count and the full/empty flags.
- It hides the RAM's 1-cycle registered read latency, and the RAM's zeroed read_data when read_en is low, behind a 2-entry output skid buffer.

Parameters:
- DATA_W, 6, payload width; equals the RAM data width.
- ADDR_W, 8, RAM address width.
- DEPTH, 12, number of usable RAM entries (1..2**ADDR_W); need not be a power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller can accept data.
- in_data  in  DATA_W  producer payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  DATA_W  head-of-FIFO payload.
- ram_write_en  out  1  to RAM write_en.
- ram_write_addr  out  ADDR_W  to RAM write_addr.
- ram_write_data  out  DATA_W  to RAM write_data.
- ram_read_en  out  1  to RAM read_en.
- ram_read_addr  out  ADDR_W  to RAM read_addr.
- ram_read_data  in  DATA_W  from RAM read_data; registered, valid 1 cycle after ram_read_en.
- fill_level  out  ADDR_W+2  total entries held: RAM + in-flight read + skid.
- empty  out  1  fill_level == 0.
- full  out  1  mem_count == DEPTH.

Behaviour:
- Reset (rst high, async):
  - wr_ptr, rd_ptr, mem_count, rd_pending, out_valid, skid_valid, out_data and skid data all clear to 0.
  - in_ready is forced 0 while rst is high.
  - RAM contents are never relied on after reset.
  - Reset mid-stream discards all held data; there is no partial recovery.
- Push: push = in_valid & in_ready.
  - ram_write_en = push (combinational), ram_write_addr = wr_ptr, ram_write_data = in_data.
  - wr_ptr advances at the same edge.
- in_ready = !rst & (mem_count < DEPTH). No write when full, even if a read is issued in the same cycle; this keeps the full decision registered-only.
- Pointer wrap: a pointer at DEPTH-1 goes to 0, never to DEPTH. Applies to both pointers and covers non-power-of-two DEPTH.
- Pop: pop = out_valid & out_ready.
- Read issue:
  - ram_read_en = (mem_count != 0) & ((out_valid + skid_valid + rd_pending - pop) < 2).
  - ram_read_addr = rd_ptr; rd_ptr advances when ram_read_en is high.
  - rd_pending is the registered copy of ram_read_en.
- mem_count: +1 on push only, -1 on read issue only, unchanged on both.
- Read/write collision is impossible: reads only target entries counted before this cycle, so the RAM read-during-write behaviour is irrelevant.
- Capture: in a cycle with rd_pending=1, ram_read_data is captured at the next edge.
  - It goes to out_data if the out register is empty or being popped, and skid is empty.
  - Otherwise it goes to the skid register.
  - On pop with skid_valid, skid moves to out_data; ordering is strictly FIFO.
- Latency: push accepted at edge E; out_valid rises after edge E+2 when the FIFO was empty.
- Throughput: sustained 1 push and 1 pop per cycle.
- Capacity: DEPTH + 2 entries (RAM + skid pair).
- out_data holds its value while out_valid & !out_ready, with no glitching or zeroing. out_data is undefined-but-stable after pop when out_valid=0.
- fill_level = mem_count + rd_pending + out_valid + skid_valid.

Decomposition:
- Shared package ram_fifo_pkg: DATA_W, ADDR_W and DEPTH constants, and a ptr_t typedef (ADDR_W bits) used by this block and the RAM.
- One sub-module, ram_fifo_skid: the 2-entry output register/skid pair with the capture/pop logic. Pointer, count and read-issue logic stay in ram_fifo_ctrl.

Test Plan:
- Reset then idle, with in_valid=0 and out_ready=1 -> out_valid=0, empty=1, fill_level=0, ram_write_en=0, ram_read_en=0.
- Single push of 6'h2A at edge 0 with out_ready=1 -> ram_write_addr=0; ram_read_en=1 in cycle 1 at addr 0; out_valid=1 with out_data=6'h2A after edge 2; popped next edge.
- Push 14 values (1..14) with out_ready=0 -> in_ready drops after the 14th accept (12 RAM + 2 skid), full=1, fill_level=14. Then raise out_ready -> outputs 1..14 in order, one per cycle.
- Continuous stream of 30 values with in_valid=1 and out_ready=1 -> after a 2-cycle fill, one output per cycle. Pointers wrap 11->0 twice; no loss or duplication.
- Random out_ready stalls (50%) over 200 pushes -> output sequence equals input sequence; out_data stable during each stall.
- Assert rst mid-stream with 5 entries held -> all flags and counters reset immediately (asynchronously), in_ready=0 during rst. After release, the next push 6'h15 comes out first.
